// File: rtl/ir_transmit.sv
// NEC-format infrared transmitter: serialises a 32-bit frame into lead/space/pulse-distance
// bits/stop mark, with an active-low demodulated level and a carrier-gated LED drive.
module ir_transmit #(
  parameter int LEAD_MARK    = 450000,
  parameter int LEAD_SPACE   = 225000,
  parameter int BIT_MARK     = 28000,
  parameter int ZERO_SPACE   = 28000,
  parameter int ONE_SPACE    = 84500,
  parameter int FRAME_GAP    = 2000000,
  parameter int CARRIER_HALF = 658
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iSTART,
  input  logic [31:0] iDATA,
  output logic        oBUSY,
  output logic        oDONE,
  output logic        oIRDA,
  output logic        oIR_LED
);

  typedef enum logic [2:0] {
    IDLE,
    LEAD_M,
    LEAD_S,
    BIT_M,
    BIT_S,
    STOP_M,
    GAP
  } state_t;

  // The phase counter is sized from the longest duration; the 40 ms gap needs more than 19 bits.
  localparam int MAX_1   = (LEAD_MARK > LEAD_SPACE) ? LEAD_MARK : LEAD_SPACE;
  localparam int MAX_2   = (MAX_1 > BIT_MARK)       ? MAX_1     : BIT_MARK;
  localparam int MAX_3   = (MAX_2 > ZERO_SPACE)     ? MAX_2     : ZERO_SPACE;
  localparam int MAX_4   = (MAX_3 > ONE_SPACE)      ? MAX_3     : ONE_SPACE;
  localparam int MAX_DUR = (MAX_4 > FRAME_GAP)      ? MAX_4     : FRAME_GAP;
  localparam int CNT_W   = (MAX_DUR > 1) ? $clog2(MAX_DUR) : 1;
  localparam int DIV_W   = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;

  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_val;
  logic               cnt_load;
  logic               expired;
  logic [31:0]        shreg_q;
  logic [5:0]         idx_q;
  logic               latch_data;
  logic               shift_bit;
  logic               done_d;
  logic               mark_q;
  logic               mark_d;
  logic [DIV_W-1:0]   div_q;
  logic               led_q;
  logic               irda_q;
  logic               busy_q;
  logic               done_q;

  function automatic logic is_mark(input state_t s);
    return (s == LEAD_M) || (s == BIT_M) || (s == STOP_M);
  endfunction

  assign expired = (cnt_q == '0);
  assign mark_q  = is_mark(state_q);
  assign mark_d  = is_mark(state_d);

  // NOTE: every signal driven here gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d    = state_q;
    cnt_load   = 1'b0;
    cnt_val    = '0;
    latch_data = 1'b0;
    shift_bit  = 1'b0;
    done_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (iSTART) begin
          state_d    = LEAD_M;
          cnt_load   = 1'b1;
          cnt_val    = CNT_W'(LEAD_MARK - 1);
          latch_data = 1'b1;
        end
      end
      LEAD_M: begin
        if (expired) begin
          state_d  = LEAD_S;
          cnt_load = 1'b1;
          cnt_val  = CNT_W'(LEAD_SPACE - 1);
        end
      end
      LEAD_S: begin
        if (expired) begin
          state_d  = BIT_M;
          cnt_load = 1'b1;
          cnt_val  = CNT_W'(BIT_MARK - 1);
        end
      end
      BIT_M: begin
        if (expired) begin
          state_d  = BIT_S;
          cnt_load = 1'b1;
          cnt_val  = shreg_q[0] ? CNT_W'(ONE_SPACE - 1) : CNT_W'(ZERO_SPACE - 1);
        end
      end
      BIT_S: begin
        if (expired) begin
          shift_bit = 1'b1;
          state_d   = (idx_q == 6'd31) ? STOP_M : BIT_M;
          cnt_load  = 1'b1;
          cnt_val   = CNT_W'(BIT_MARK - 1);
        end
      end
      STOP_M: begin
        if (expired) begin
          state_d  = GAP;
          cnt_load = 1'b1;
          cnt_val  = CNT_W'(FRAME_GAP - 1);
          done_d   = 1'b1;
        end
      end
      GAP: begin
        if (expired) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      if (cnt_load) begin
        cnt_q <= cnt_val;
      end else if (!expired) begin
        cnt_q <= cnt_q - 1'b1;
      end
      if (latch_data) begin
        shreg_q <= iDATA;
        idx_q   <= '0;
      end else if (shift_bit) begin
        shreg_q <= shreg_q >> 1;
        idx_q   <= idx_q + 6'd1;
      end
    end
  end

  // NOTE: outputs are registered from the next state so they change on the same edge as the state.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      irda_q <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      irda_q <= !mark_d;
      busy_q <= (state_d != IDLE);
      done_q <= done_d;
    end
  end

  // Carrier restarts high with a cleared divider on every mark entry.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      div_q <= '0;
      led_q <= 1'b0;
    end else if (!mark_d) begin
      div_q <= '0;
      led_q <= 1'b0;
    end else if (!mark_q) begin
      div_q <= '0;
      led_q <= 1'b1;
    end else if (div_q == DIV_W'(CARRIER_HALF - 1)) begin
      div_q <= '0;
      led_q <= ~led_q;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  assign oIRDA   = irda_q;
  assign oIR_LED = led_q;
  assign oBUSY   = busy_q;
  assign oDONE   = done_q;

endmodule

// File: tb/tb_ir_transmit.sv
// Bench for ir_transmit with shortened durations: every cycle of each frame is compared
// against a waveform built from the NEC segment rules.
module tb_ir_transmit;

  localparam int LM = 40;
  localparam int LS = 20;
  localparam int BM = 8;
  localparam int ZS = 6;
  localparam int OS = 14;
  localparam int FG = 50;
  localparam int CH = 3;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic        iSTART;
  logic [31:0] iDATA;
  logic        oBUSY;
  logic        oDONE;
  logic        oIRDA;
  logic        oIR_LED;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct packed {
    logic irda;
    logic led;
    logic busy;
    logic done;
  } exp_t;

  exp_t exp_q[$];

  ir_transmit #(
    .LEAD_MARK   (LM),
    .LEAD_SPACE  (LS),
    .BIT_MARK    (BM),
    .ZERO_SPACE  (ZS),
    .ONE_SPACE   (OS),
    .FRAME_GAP   (FG),
    .CARRIER_HALF(CH)
  ) dut (
    .iCLK   (iCLK),
    .iRST   (iRST),
    .iSTART (iSTART),
    .iDATA  (iDATA),
    .oBUSY  (oBUSY),
    .oDONE  (oDONE),
    .oIRDA  (oIRDA),
    .oIR_LED(oIR_LED)
  );

  always #5 iCLK = ~iCLK;

  function automatic logic [3:0] observed();
    return {oIRDA, oIR_LED, oBUSY, oDONE};
  endfunction

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed(irda,led,busy,done)=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One segment of constant level; the carrier is high for the first CH cycles of a mark.
  task automatic push_seg(input bit mark, input int len, input bit first_done);
    for (int t = 0; t < len; t++) begin
      exp_t e;
      e.irda = !mark;
      e.led  = mark && (((t / CH) % 2) == 0);
      e.busy = 1'b1;
      e.done = first_done && (t == 0);
      exp_q.push_back(e);
    end
  endtask

  task automatic build(input logic [31:0] d);
    exp_t idle_e;
    exp_q.delete();
    push_seg(1, LM, 0);
    push_seg(0, LS, 0);
    for (int i = 0; i < 32; i++) begin
      push_seg(1, BM, 0);
      push_seg(0, d[i] ? OS : ZS, 0);
    end
    push_seg(1, BM, 0);
    push_seg(0, FG, 1);
    idle_e = 4'b1000;
    exp_q.push_back(idle_e);
  endtask

  // mode 0: start released after the first edge; 1: random re-pulses and data churn
  // while busy; 2: start held high with iDATA switched to nxt for the following frame.
  task automatic follow(input string name, input logic [31:0] d, input int mode,
                        input int abort_at, input logic [31:0] nxt);
    int flen;
    build(d);
    flen = exp_q.size() - FG - 1;
    for (int c = 0; c < exp_q.size(); c++) begin
      @(posedge iCLK);
      #1;
      check($sformatf("%s cyc%0d", name, c), observed(), exp_q[c]);
      if (c == abort_at) begin
        iRST = 1'b1;
        return;
      end
      case (mode)
        0: iSTART = 1'b0;
        1: begin
          iSTART = (c < flen) && ($urandom_range(0, 1) == 1);
          iDATA  = $urandom;
        end
        default: begin
          iSTART = 1'b1;
          iDATA  = nxt;
        end
      endcase
    end
  endtask

  task automatic send(input string name, input logic [31:0] d, input int mode,
                      input int abort_at, input logic [31:0] nxt);
    iDATA  = d;
    iSTART = 1'b1;
    follow(name, d, mode, abort_at, nxt);
  endtask

  initial begin
    logic [31:0] d;
    int abort_idx;

    iRST   = 1'b1;
    iSTART = 1'b0;
    iDATA  = '0;
    repeat (5) @(posedge iCLK);
    #1;
    check("reset", observed(), 4'b1000);

    iRST  = 1'b0;
    iDATA = 32'hDEADBEEF;
    repeat (3) begin
      @(posedge iCLK);
      #1;
      check("idle_no_start", observed(), 4'b1000);
    end

    send("single", 32'hE51ABF40, 0, -1, '0);
    send("zeros", 32'h0000_0000, 0, -1, '0);
    send("ones", 32'hFFFF_FFFF, 0, -1, '0);
    send("busy_churn", 32'h12C4_A55A, 1, -1, '0);

    send("hold_a", 32'h00FF_F00F, 2, -1, 32'h8000_0001);
    follow("hold_b", 32'h8000_0001, 0, -1, '0);

    d = 32'h5A5A_C3C3;
    abort_idx = LM + LS;
    for (int i = 0; i < 10; i++) abort_idx += BM + (d[i] ? OS : ZS);
    abort_idx += BM + 2;
    send("abort", d, 0, abort_idx, '0);
    @(posedge iCLK);
    #1;
    check("abort_reset", observed(), 4'b1000);
    iRST = 1'b0;
    repeat (5) begin
      @(posedge iCLK);
      #1;
      check("abort_idle", observed(), 4'b1000);
    end
    send("fresh", d, 0, -1, '0);

    repeat (6) begin
      d = $urandom;
      send($sformatf("rand_%08h", d), d, int'($urandom_range(0, 1)), -1, '0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
